// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts cycles an instruction-memory request waits unanswered; raises a sticky error at TIMEOUT.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic ready,
    output logic fetch_error
);

    logic [7:0] wait_cnt_q;
    logic       error_q;
    logic       waiting;

    assign waiting     = req & ~ready;
    assign fetch_error = error_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            if (!waiting) begin
                wait_cnt_q <= 8'd0;
            end else if (wait_cnt_q != 8'(TIMEOUT)) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            // Flag on the cycle the count reaches TIMEOUT.
            if (waiting && wait_cnt_q == 8'(TIMEOUT - 1)) begin
                error_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, imem req/ready handshake, one-entry output register and redirects.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hzdWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instructionOut,
    output logic [31:0] pcOut,
    output logic        fetch_valid,
    output logic        if_flush,
    output logic        fetch_error
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  drain_addr_q;
    logic [31:0]  instr_q;
    logic [31:0]  pcout_q;
    logic         req_q;
    logic         valid_q;
    logic         kill_q;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_inc;

    assign redirect = branch_taken | jump;
    assign pc_inc   = pc_q + 32'(INSTR_BYTES);

    always_comb begin
        target       = branch_taken ? branch_target : jump_target;
        target[1:0]  = 2'b00;
    end

    assign if_flush       = redirect;
    assign imem_req       = req_q;
    // A killed request keeps its original address while pc already points at the target.
    assign imem_addr      = kill_q ? drain_addr_q : pc_q;
    assign instructionOut = instr_q;
    assign pcOut          = pcout_q;
    assign fetch_valid    = valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pcout_q      <= 32'h0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    if (redirect) begin
                        pc_q <= target;
                    end
                end
                FETCH: begin
                    if (valid_q && hzdWrite) begin
                        valid_q <= 1'b0;
                    end
                    if (redirect) begin
                        pc_q    <= target;
                        valid_q <= 1'b0;
                        if (req_q && !imem_ready) begin
                            kill_q       <= 1'b1;
                            drain_addr_q <= pc_q;
                            state_q      <= DRAIN;
                        end else if (req_q) begin
                            req_q <= 1'b0;
                        end
                    end else if (req_q && imem_ready) begin
                        instr_q <= imem_rdata;
                        pcout_q <= pc_inc;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc;
                        req_q   <= 1'b0;
                    end else if (!req_q && (!valid_q || hzdWrite)) begin
                        req_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (imem_ready) begin
                        kill_q  <= 1'b0;
                        req_q   <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .req         (req_q),
        .ready       (imem_ready),
        .fetch_error (fetch_error)
    );

endmodule
